// File: rtl/ap_ctrl_pkg.sv
// Shared types for ap_ctrl start/ready/done/idle handshake blocks.
// Holds the responder state encoding and the watchdog-disable sentinel.
package ap_ctrl_pkg;

    localparam int STATE_W          = 2;
    localparam int TIMEOUT_DISABLED = 0;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ap_state_e;

endpackage

// File: rtl/ap_ctrl_responder_if.sv
// Initiator-facing ap_ctrl handshake bundle; master = initiator, slave = kernel side.
// No storage of its own; timing and backpressure belong to whichever block drives it.
interface ap_ctrl_responder_if #(
    parameter int ARG_W = 32,
    parameter int RET_W = 32
);
    logic             ap_start;
    logic [ARG_W-1:0] ap_arg;
    logic             ap_continue;
    logic             ap_ready;
    logic             ap_done;
    logic             ap_idle;
    logic [RET_W-1:0] ap_return;
    logic             ap_error;

    modport master (
        output ap_start, ap_arg, ap_continue,
        input  ap_ready, ap_done, ap_idle, ap_return, ap_error
    );

    modport slave (
        input  ap_start, ap_arg, ap_continue,
        output ap_ready, ap_done, ap_idle, ap_return, ap_error
    );
endinterface

// File: rtl/ap_watchdog.sv
// Run-length watchdog: counts enabled cycles from a clear, flags expiry combinationally
// in the cycle the count sits at TIMEOUT-1; no backpressure, tied off when TIMEOUT=0.
module ap_watchdog
    import ap_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 0,
    parameter int TO_W    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam bit            WD_ON = (TIMEOUT != TIMEOUT_DISABLED);
    localparam logic [TO_W-1:0] LIMIT = WD_ON ? TO_W'(TIMEOUT - 1) : '0;

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    // Saturate at the limit so a stalled enable can never wrap past it.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && WD_ON && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = WD_ON && enable && (cnt_q == LIMIT);

endmodule

// File: rtl/ap_ctrl_responder.sv
// Kernel side of ap_ctrl_hs/ap_ctrl_chain wrapping a custom RTL core; ap_ready/core_start 1 cycle
// after accepting ap_start, ap_done 1 cycle after core_done. One task at a time; start held off in RUN/held DONE.
module ap_ctrl_responder
    import ap_ctrl_pkg::*;
#(
    parameter int ARG_W   = 32,
    parameter int RET_W   = 32,
    parameter int CHAIN   = 0,
    parameter int TIMEOUT = 0,
    parameter int TO_W    = 16,
    parameter int CNT_W   = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    ap_ctrl_responder_if.slave ap_if,
    output logic             core_start,
    output logic [ARG_W-1:0] core_arg,
    input  logic             core_done,
    input  logic [RET_W-1:0] core_result,
    output logic [CNT_W-1:0] task_cnt,
    output logic             spurious
);

    ap_state_e        state_q, state_d;
    logic             ap_ready_q, ap_ready_d;
    logic             ap_done_q, ap_done_d;
    logic             ap_idle_q, ap_idle_d;
    logic [RET_W-1:0] ap_return_q, ap_return_d;
    logic             ap_error_q, ap_error_d;
    logic             core_start_q, core_start_d;
    logic [ARG_W-1:0] core_arg_q, core_arg_d;
    logic [CNT_W-1:0] task_cnt_q, task_cnt_d;
    logic             spurious_q, spurious_d;
    logic             accept;
    logic             wd_expired;

    ap_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk     (ap_clk),
        .rst     (ap_rst),
        .clear   (state_q != RUN),
        .enable  (state_q == RUN),
        .expired (wd_expired)
    );

    always_comb begin
        state_d      = state_q;
        ap_return_d  = ap_return_q;
        ap_error_d   = ap_error_q;
        core_arg_d   = core_arg_q;
        task_cnt_d   = task_cnt_q;
        ap_ready_d   = 1'b0;
        core_start_d = 1'b0;
        accept       = 1'b0;
        spurious_d   = spurious_q | (core_done && (state_q != RUN));

        case (state_q)
            IDLE: begin
                accept = ap_if.ap_start;
            end
            RUN: begin
                // A real completion beats a watchdog expiry landing on the same cycle.
                if (core_done) begin
                    ap_return_d = core_result;
                    ap_error_d  = 1'b0;
                    task_cnt_d  = task_cnt_q + CNT_W'(1);
                    state_d     = DONE;
                end else if (wd_expired) begin
                    ap_error_d  = 1'b1;
                    task_cnt_d  = task_cnt_q + CNT_W'(1);
                    state_d     = DONE;
                end
            end
            DONE: begin
                if ((CHAIN == 0) || ap_if.ap_continue) begin
                    if (ap_if.ap_start) begin
                        accept = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d      = RUN;
            core_arg_d   = ap_if.ap_arg;
            ap_ready_d   = 1'b1;
            core_start_d = 1'b1;
        end

        ap_done_d = (state_d == DONE);
        ap_idle_d = (state_d == IDLE);
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q      <= IDLE;
            ap_ready_q   <= 1'b0;
            ap_done_q    <= 1'b0;
            ap_idle_q    <= 1'b1;
            ap_return_q  <= '0;
            ap_error_q   <= 1'b0;
            core_start_q <= 1'b0;
            core_arg_q   <= '0;
            task_cnt_q   <= '0;
            spurious_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ap_ready_q   <= ap_ready_d;
            ap_done_q    <= ap_done_d;
            ap_idle_q    <= ap_idle_d;
            ap_return_q  <= ap_return_d;
            ap_error_q   <= ap_error_d;
            core_start_q <= core_start_d;
            core_arg_q   <= core_arg_d;
            task_cnt_q   <= task_cnt_d;
            spurious_q   <= spurious_d;
        end
    end

    assign ap_if.ap_ready  = ap_ready_q;
    assign ap_if.ap_done   = ap_done_q;
    assign ap_if.ap_idle   = ap_idle_q;
    assign ap_if.ap_return = ap_return_q;
    assign ap_if.ap_error  = ap_error_q;
    assign core_start      = core_start_q;
    assign core_arg        = core_arg_q;
    assign task_cnt        = task_cnt_q;
    assign spurious        = spurious_q;

endmodule

// File: tb/tb_ap_ctrl_responder.sv
// Directed bench: handshake-mode responder with an 8-cycle watchdog, plus a chain-mode responder.
module tb_ap_ctrl_responder;

    logic ap_clk = 1'b0;
    logic ap_rst;
    always #5 ap_clk = ~ap_clk;

    int checks   = 0;
    int failures = 0;

    ap_ctrl_responder_if #(.ARG_W(32), .RET_W(32)) ifh ();
    ap_ctrl_responder_if #(.ARG_W(32), .RET_W(32)) ifc ();

    logic        h_core_start, c_core_start;
    logic [31:0] h_core_arg, c_core_arg;
    logic        h_core_done, c_core_done;
    logic [31:0] h_core_result, c_core_result;
    logic [15:0] h_task_cnt, c_task_cnt;
    logic        h_spurious, c_spurious;

    ap_ctrl_responder #(
        .ARG_W(32), .RET_W(32), .CHAIN(0), .TIMEOUT(8), .TO_W(16), .CNT_W(16)
    ) dut_hs (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .ap_if       (ifh),
        .core_start  (h_core_start),
        .core_arg    (h_core_arg),
        .core_done   (h_core_done),
        .core_result (h_core_result),
        .task_cnt    (h_task_cnt),
        .spurious    (h_spurious)
    );

    ap_ctrl_responder #(
        .ARG_W(32), .RET_W(32), .CHAIN(1), .TIMEOUT(0), .TO_W(16), .CNT_W(16)
    ) dut_ch (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .ap_if       (ifc),
        .core_start  (c_core_start),
        .core_arg    (c_core_arg),
        .core_done   (c_core_done),
        .core_result (c_core_result),
        .task_cnt    (c_task_cnt),
        .spurious    (c_spurious)
    );

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL tb_global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        ap_rst          = 1'b1;
        ifh.ap_start    = 1'b0;
        ifh.ap_arg      = '0;
        ifh.ap_continue = 1'b0;
        ifc.ap_start    = 1'b0;
        ifc.ap_arg      = '0;
        ifc.ap_continue = 1'b0;
        h_core_done     = 1'b0;
        h_core_result   = '0;
        c_core_done     = 1'b0;
        c_core_result   = '0;
        step();
        step();
        ap_rst = 1'b0;
        step();

        // Reset state
        chk("rst_idle",       32'(ifh.ap_idle), 32'd1);
        chk("rst_ready",      32'(ifh.ap_ready), 32'd0);
        chk("rst_done",       32'(ifh.ap_done), 32'd0);
        chk("rst_core_start", 32'(h_core_start), 32'd0);
        chk("rst_task_cnt",   32'(h_task_cnt), 32'd0);
        chk("rst_core_arg",   h_core_arg, 32'h0);
        chk("rst_spurious",   32'(h_spurious), 32'd0);
        chk("rst_ch_idle",    32'(ifc.ap_idle), 32'd1);

        // Single task: core_done 5 cycles after core_start
        ifh.ap_start = 1'b1;
        ifh.ap_arg   = 32'h1234;
        step();
        chk("t1_ready",      32'(ifh.ap_ready), 32'd1);
        chk("t1_core_start", 32'(h_core_start), 32'd1);
        chk("t1_idle",       32'(ifh.ap_idle), 32'd0);
        chk("t1_core_arg",   h_core_arg, 32'h1234);
        ifh.ap_start = 1'b0;
        ifh.ap_arg   = 32'hFFFF;
        step();
        chk("t1_ready_pulse", 32'(ifh.ap_ready), 32'd0);
        chk("t1_start_pulse", 32'(h_core_start), 32'd0);
        chk("t1_arg_stable",  h_core_arg, 32'h1234);
        repeat (4) step();
        chk("t1_no_early_done", 32'(ifh.ap_done), 32'd0);
        h_core_done   = 1'b1;
        h_core_result = 32'hBEEF;
        step();
        h_core_done = 1'b0;
        chk("t1_done",     32'(ifh.ap_done), 32'd1);
        chk("t1_return",   ifh.ap_return, 32'hBEEF);
        chk("t1_error",    32'(ifh.ap_error), 32'd0);
        chk("t1_task_cnt", 32'(h_task_cnt), 32'd1);
        chk("t1_done_idle", 32'(ifh.ap_idle), 32'd0);
        step();
        chk("t1_done_pulse", 32'(ifh.ap_done), 32'd0);
        chk("t1_back_idle",  32'(ifh.ap_idle), 32'd1);
        chk("t1_ret_hold",   ifh.ap_return, 32'hBEEF);

        // Back-to-back: ap_start held through ap_done
        ifh.ap_start = 1'b1;
        ifh.ap_arg   = 32'h0A0A;
        step();
        chk("b2b_ready0", 32'(ifh.ap_ready), 32'd1);
        ifh.ap_arg = 32'h0B0B;
        step();
        chk("b2b_run_no_ready", 32'(ifh.ap_ready), 32'd0);
        chk("b2b_run_arg",      h_core_arg, 32'h0A0A);
        h_core_done   = 1'b1;
        h_core_result = 32'h1111;
        step();
        h_core_done = 1'b0;
        chk("b2b_done",      32'(ifh.ap_done), 32'd1);
        chk("b2b_done_rdy",  32'(ifh.ap_ready), 32'd0);
        chk("b2b_return",    ifh.ap_return, 32'h1111);
        step();
        chk("b2b_ready1",    32'(ifh.ap_ready), 32'd1);
        chk("b2b_done_low",  32'(ifh.ap_done), 32'd0);
        chk("b2b_idle_low",  32'(ifh.ap_idle), 32'd0);
        chk("b2b_task_cnt",  32'(h_task_cnt), 32'd2);
        chk("b2b_core_arg",  h_core_arg, 32'h0B0B);
        ifh.ap_start = 1'b0;

        // Watchdog expiry: no core_done for 8 RUN cycles
        repeat (7) step();
        chk("wd_not_yet", 32'(ifh.ap_done), 32'd0);
        step();
        chk("wd_done",     32'(ifh.ap_done), 32'd1);
        chk("wd_error",    32'(ifh.ap_error), 32'd1);
        chk("wd_ret_kept", ifh.ap_return, 32'h1111);
        chk("wd_task_cnt", 32'(h_task_cnt), 32'd3);
        step();
        chk("wd_idle", 32'(ifh.ap_idle), 32'd1);

        // core_done on the expiry cycle wins
        ifh.ap_start = 1'b1;
        ifh.ap_arg   = 32'h5;
        step();
        ifh.ap_start = 1'b0;
        repeat (7) step();
        h_core_done   = 1'b1;
        h_core_result = 32'h2222;
        step();
        h_core_done = 1'b0;
        chk("wdtie_done",   32'(ifh.ap_done), 32'd1);
        chk("wdtie_error",  32'(ifh.ap_error), 32'd0);
        chk("wdtie_return", ifh.ap_return, 32'h2222);
        chk("wdtie_cnt",    32'(h_task_cnt), 32'd4);
        step();

        // Stray core_done while idle
        chk("sp_before", 32'(h_spurious), 32'd0);
        h_core_done   = 1'b1;
        h_core_result = 32'h9999;
        step();
        h_core_done = 1'b0;
        chk("sp_set",      32'(h_spurious), 32'd1);
        chk("sp_ret_kept", ifh.ap_return, 32'h2222);
        chk("sp_cnt_kept", 32'(h_task_cnt), 32'd4);
        chk("sp_no_done",  32'(ifh.ap_done), 32'd0);
        step();
        chk("sp_sticky", 32'(h_spurious), 32'd1);

        // Chain mode: ap_done held until ap_continue
        ifc.ap_start = 1'b1;
        ifc.ap_arg   = 32'hC0DE;
        step();
        chk("ch_ready",      32'(ifc.ap_ready), 32'd1);
        chk("ch_core_start", 32'(c_core_start), 32'd1);
        chk("ch_core_arg",   c_core_arg, 32'hC0DE);
        ifc.ap_start  = 1'b0;
        c_core_done   = 1'b1;
        c_core_result = 32'hCAFE;
        step();
        c_core_done = 1'b0;
        chk("ch_done",   32'(ifc.ap_done), 32'd1);
        chk("ch_return", ifc.ap_return, 32'hCAFE);
        chk("ch_error",  32'(ifc.ap_error), 32'd0);
        chk("ch_cnt",    32'(c_task_cnt), 32'd1);
        ifc.ap_start = 1'b1;
        ifc.ap_arg   = 32'hD00D;
        for (int i = 1; i < 10; i++) begin
            step();
            chk("ch_hold_done",     32'(ifc.ap_done), 32'd1);
            chk("ch_hold_no_ready", 32'(ifc.ap_ready), 32'd0);
        end
        ifc.ap_continue = 1'b1;
        step();
        ifc.ap_continue = 1'b0;
        ifc.ap_start    = 1'b0;
        chk("ch_cont_ready", 32'(ifc.ap_ready), 32'd1);
        chk("ch_cont_done",  32'(ifc.ap_done), 32'd0);
        chk("ch_cont_arg",   c_core_arg, 32'hD00D);
        c_core_done   = 1'b1;
        c_core_result = 32'h0F0F;
        step();
        c_core_done = 1'b0;
        chk("ch2_done", 32'(ifc.ap_done), 32'd1);
        chk("ch2_cnt",  32'(c_task_cnt), 32'd2);
        ifc.ap_continue = 1'b1;
        step();
        ifc.ap_continue = 1'b0;
        chk("ch2_release_idle", 32'(ifc.ap_idle), 32'd1);
        chk("ch2_release_done", 32'(ifc.ap_done), 32'd0);
        chk("ch_spurious",      32'(c_spurious), 32'd0);

        // Reset during RUN: immediate idle values, later core_done only marks spurious
        ifh.ap_start = 1'b1;
        ifh.ap_arg   = 32'h77;
        step();
        ifh.ap_start = 1'b0;
        repeat (3) step();
        chk("mr_running", 32'(ifh.ap_idle), 32'd0);
        ap_rst = 1'b1;
        #1;
        chk("mr_idle",     32'(ifh.ap_idle), 32'd1);
        chk("mr_done",     32'(ifh.ap_done), 32'd0);
        chk("mr_cnt",      32'(h_task_cnt), 32'd0);
        chk("mr_core_arg", h_core_arg, 32'h0);
        chk("mr_spurious", 32'(h_spurious), 32'd0);
        chk("mr_ch_cnt",   32'(c_task_cnt), 32'd0);
        step();
        ap_rst = 1'b0;
        step();
        h_core_done   = 1'b1;
        h_core_result = 32'h5555;
        step();
        h_core_done = 1'b0;
        chk("mr_late_spurious", 32'(h_spurious), 32'd1);
        chk("mr_late_cnt",      32'(h_task_cnt), 32'd0);
        chk("mr_late_return",   ifh.ap_return, 32'h0);
        chk("mr_late_done",     32'(ifh.ap_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
